// File: rtl/svsg_pkg.sv
// Shared definitions for the four-digit seven-segment scanner: segment
// patterns (bit7=a .. bit1=g, bit0=dp, active-high), converter state type,
// value limits and the BCD-to-segment decode helper.
package svsg_pkg;

    localparam int BIN_W = 14;
    localparam int NDIG  = 4;

    localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    // Map one BCD digit to its segment pattern; non-decimal codes go dark.
    function automatic logic [7:0] segDecode(input logic [3:0] d);
        case (d)
            4'd0:    segDecode = SEG_0;
            4'd1:    segDecode = SEG_1;
            4'd2:    segDecode = SEG_2;
            4'd3:    segDecode = SEG_3;
            4'd4:    segDecode = SEG_4;
            4'd5:    segDecode = SEG_5;
            4'd6:    segDecode = SEG_6;
            4'd7:    segDecode = SEG_7;
            4'd8:    segDecode = SEG_8;
            4'd9:    segDecode = SEG_9;
            default: segDecode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/svsg_dd_conv.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// BIN_W iterations per conversion. The visible BCD result only changes once
// a conversion completes, so the display never sees partial sums. A start
// pulse always (re)loads, so the most recent value wins.
module svsg_dd_conv
    import svsg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [BIN_W-1:0]     i_bin,
    output logic                 o_busy,
    output logic [4*NDIG-1:0]    o_bcd
);

    localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

    conv_state_t           r_state;
    logic [3:0]            r_iter;
    logic [BIN_W-1:0]      r_bin;
    logic [4*NDIG-1:0]     r_acc;
    logic [4*NDIG-1:0]     r_bcd;
    logic                  r_busy;
    logic [4*NDIG-1:0]     w_adj;
    logic [4*NDIG-1:0]     w_accNext;

    // Add 3 to every accumulator nibble that is 5 or more before the shift.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < NDIG; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_accNext = {w_adj[4*NDIG-2:0], r_bin[BIN_W-1]};

    // Converter FSM: load on start, iterate in CONV, publish result on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_iter  <= 4'd0;
            r_bin   <= '0;
            r_acc   <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_state <= CONV;
            r_iter  <= 4'd0;
            r_bin   <= i_bin;
            r_acc   <= '0;
            r_busy  <= 1'b1;
        end else if (r_state == CONV) begin
            r_acc  <= w_accNext;
            r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
            r_iter <= r_iter + 4'd1;
            if (r_iter == LAST_ITER) begin
                r_bcd   <= w_accNext;
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/svsg_scan4_wb.sv
// Wishbone-slave four-digit multiplexed seven-segment driver. Firmware
// writes a binary value (clamped to 9999) at BASE and an enable bit at
// BASE+4; a double-dabble converter produces BCD digits which a refresh
// scanner shows one at a time with one-hot digit enables.
// Optional build macro SVSG_LZ_BLANK_EN enables leading-zero blanking.
module svsg_scan4_wb
    import svsg_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h3000_0010,
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  svsg,
    output logic [3:0]  dig_en,
    output logic [11:0] io_oeb
);

    logic                r_ack;
    logic [31:0]         r_dat;
    logic [BIN_W-1:0]    r_value;
    logic                r_ovf;
    logic                r_en;
    logic [15:0]         r_cnt;
    logic [1:0]          r_idx;
    logic [7:0]          r_svsg;
    logic [3:0]          r_digEn;

    logic                w_selValue;
    logic                w_selCtrl;
    logic                w_accept;
    logic                w_wrValue;
    logic                w_wrCtrl;
    logic [BIN_W-1:0]    w_binIn;
    logic                w_over;
    logic [BIN_W-1:0]    w_binClamped;
    logic                w_busy;
    logic [4*NDIG-1:0]   w_bcd;
    logic [3:0]          w_digit;
    logic [7:0]          w_seg;
    logic                w_unused;

    assign w_selValue   = (wbs_adr_i == BASE);
    assign w_selCtrl    = (wbs_adr_i == BASE + 32'd4);
    assign w_accept     = wbs_cyc_i & wbs_stb_i & (w_selValue | w_selCtrl) & ~r_ack;
    assign w_wrValue    = w_accept & wbs_we_i & w_selValue;
    assign w_wrCtrl     = w_accept & wbs_we_i & w_selCtrl;
    assign w_binIn      = wbs_dat_i[BIN_W-1:0];
    assign w_over       = (w_binIn > MAX_VAL);
    assign w_binClamped = w_over ? MAX_VAL : w_binIn;

    assign w_unused = &{1'b0, wbs_sel_i, wbs_dat_i[31:BIN_W]};

    svsg_dd_conv u_conv (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_wrValue),
        .i_bin   (w_binClamped),
        .o_busy  (w_busy),
        .o_bcd   (w_bcd)
    );

    // Bus side: single-cycle ack, registered read data, VALUE/CTRL registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dat   <= 32'd0;
            r_value <= '0;
            r_ovf   <= 1'b0;
            r_en    <= 1'b1;
        end else begin
            r_ack <= w_accept;
            if (w_accept && !wbs_we_i) begin
                r_dat <= w_selValue ? {18'b0, r_value} : {29'b0, r_ovf, w_busy, r_en};
            end
            if (w_wrValue) begin
                r_value <= w_binClamped;
                r_ovf   <= w_over;
            end
            if (w_wrCtrl) begin
                r_en <= wbs_dat_i[0];
            end
        end
    end

    // Refresh timer: hold each digit REFRESH_DIV cycles, then step to the next.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 16'd0;
            r_idx <= 2'd0;
        end else if (r_cnt == REFRESH_DIV - 16'd1) begin
            r_cnt <= 16'd0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign w_digit = w_bcd[{r_idx, 2'b00} +: 4];

`ifdef SVSG_LZ_BLANK_EN
    logic w_lzBlank;
    assign w_lzBlank = (r_idx != 2'd0) && ((w_bcd >> {r_idx, 2'b00}) == '0);
    assign w_seg     = w_lzBlank ? SEG_BLANK : segDecode(w_digit);
`else
    assign w_seg = segDecode(w_digit);
`endif

    // Pad drivers: one cycle behind the scan index, dark when disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_svsg  <= 8'h00;
            r_digEn <= 4'b0000;
        end else begin
            r_digEn <= r_en ? (4'b0001 << r_idx) : 4'b0000;
            r_svsg  <= r_en ? w_seg : SEG_BLANK;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign svsg      = r_svsg;
    assign dig_en    = r_digEn;
    assign io_oeb    = 12'h000;

endmodule

// File: tb/tb_svsg_scan4_wb.sv
// Self-checking bench for svsg_scan4_wb. A behavioural model tracks the
// shown number, enable, conversion countdown and scan position from the
// cycle count, and is compared against the DUT every cycle. Directed
// scenarios add literal expectations; a randomized phase follows.
// Build with SVSG_LZ_BLANK_EN defined to check the leading-zero-blank build.
module tb_svsg_scan4_wb;

    localparam logic [31:0] BASE = 32'h3000_0010;
    localparam int          DIV  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] datIn = 32'd0;
    logic [31:0] adr = 32'd0;
    logic        ack;
    logic [31:0] datOut;
    logic [7:0]  svsg;
    logic [3:0]  digEn;
    logic [11:0] ioOeb;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    svsg_scan4_wb #(
        .BASE        (BASE),
        .REFRESH_DIV (16'(DIV))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (datIn),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (datOut),
        .svsg      (svsg),
        .dig_en    (digEn),
        .io_oeb    (ioOeb)
    );

    // One comparison: count it, and report it on a FAIL line if it differs.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Segment pattern of a single decimal digit.
    function automatic logic [7:0] segOf(input int d);
        case (d)
            0: return 8'hFC;
            1: return 8'h60;
            2: return 8'hDA;
            3: return 8'hF2;
            4: return 8'h66;
            5: return 8'hB6;
            6: return 8'hBE;
            7: return 8'hE0;
            8: return 8'hFE;
            9: return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    // Pattern expected on digit position idx when the number shown is value.
    function automatic logic [7:0] digitSeg(input int value, input int idx);
        int p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
`ifdef SVSG_LZ_BLANK_EN
        if (idx > 0 && value < p) return 8'h00;
`endif
        return segOf((value / p) % 10);
    endfunction

    // Behavioural model state.
    bit          mLive = 1'b0;
    int          mValue, mDisp, mPendVal, mPendCnt, mN;
    bit          mOvf, mEn, mAckPrev;
    bit          eAck, eRead;
    logic [7:0]  eSeg;
    logic [3:0]  eDig;
    logic [31:0] eDat;

    // Model step on every edge, then compare the DUT just after the edge.
    always @(posedge clk) begin
        bit acc;
        int idx;
        int v;
        if (reset) begin
            mLive = 1'b1;
            mValue = 0; mDisp = 0; mPendVal = 0; mPendCnt = 0; mN = 0;
            mOvf = 1'b0; mEn = 1'b1; mAckPrev = 1'b0;
            eAck = 1'b0; eRead = 1'b0; eSeg = 8'h00; eDig = 4'h0; eDat = 32'd0;
        end else if (mLive) begin
            acc   = cyc && stb && (adr == BASE || adr == BASE + 32'd4) && !mAckPrev;
            eAck  = acc;
            eRead = acc && !we;
            if (eRead) begin
                if (adr == BASE) eDat = 32'(mValue);
                else             eDat = {29'b0, mOvf, (mPendCnt > 0), mEn};
            end
            idx = (mN / DIV) % 4;
            if (mEn) begin
                eDig = 4'b0001 << idx;
                eSeg = digitSeg(mDisp, idx);
            end else begin
                eDig = 4'h0;
                eSeg = 8'h00;
            end
            mN++;
            if (acc && we && adr == BASE) begin
                v = int'(datIn[13:0]);
                mOvf = (v > 9999);
                mValue = mOvf ? 9999 : v;
                mPendVal = mValue;
                mPendCnt = 14;
            end else if (mPendCnt > 0) begin
                mPendCnt--;
                if (mPendCnt == 0) mDisp = mPendVal;
            end
            if (acc && we && adr == BASE + 32'd4) mEn = datIn[0];
            mAckPrev = acc;
        end
        #1;
        if (mLive) begin
            checkOutput("ack", 32'(ack), 32'(eAck));
            checkOutput("svsg", 32'(svsg), 32'(eSeg));
            checkOutput("dig_en", 32'(digEn), 32'(eDig));
            checkOutput("io_oeb", 32'(ioOeb), 32'd0);
            if (eRead) checkOutput("rdata", datOut, eDat);
        end
    end

    // One bus access, waiting a bounded number of cycles for the ack.
    task automatic wbAccess(input logic [31:0] a, input logic w, input logic [31:0] d,
                            output logic [31:0] rd, output bit acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; datIn = d;
        acked = 1'b0;
        rd = 32'd0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk);
            #2;
            if (ack) begin
                acked = 1'b1;
                rd = datOut;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wbWrite(input logic [31:0] a, input logic [31:0] d, input string name);
        logic [31:0] rd;
        bit acked;
        wbAccess(a, 1'b1, d, rd, acked);
        checkOutput(name, 32'(acked), 32'd1);
    endtask

    task automatic wbRead(input logic [31:0] a, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        bit acked;
        wbAccess(a, 1'b0, 32'd0, rd, acked);
        if (acked) checkOutput(name, rd, exp);
        else       checkOutput({name, "_ack"}, 32'(acked), 32'd1);
    endtask

    // Wait (bounded) for the scan to reach digit idx and check its pattern.
    task automatic checkDigit(input int idx, input logic [7:0] exp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * DIV + 4 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (digEn == (4'b0001 << idx)) begin
                seen = 1'b1;
                checkOutput(name, 32'(svsg), 32'(exp));
            end
        end
        if (!seen) checkOutput({name, "_scan"}, 32'(digEn), 32'(4'b0001 << idx));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One random bus/reset action for the randomized phase.
    task automatic applyStimulus();
        logic [31:0] rd;
        bit acked;
        int kind = $urandom_range(0, 99);
        if (kind < 35) begin
            wbAccess(BASE, 1'b1, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 9999)), rd, acked);
        end else if (kind < 45) begin
            wbAccess(BASE + 32'd4, 1'b1, ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFE) : ($urandom | 32'd1), rd, acked);
        end else if (kind < 65) begin
            wbAccess(($urandom_range(0, 1) == 0) ? BASE : BASE + 32'd4, 1'b0, 32'd0, rd, acked);
        end else if (kind < 72) begin
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = 1'b0;
            adr = ($urandom_range(0, 1) == 0) ? BASE : BASE + 32'd4;
            repeat ($urandom_range(2, 6)) @(negedge clk);
            cyc = 1'b0; stb = 1'b0;
        end else if (kind < 78) begin
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = $urandom_range(0, 1) == 1;
            adr = BASE + 32'd8 + 32'($urandom_range(0, 3) * 4);
            datIn = $urandom;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end else if (kind < 80) begin
            @(negedge clk);
            reset = 1'b1;
            repeat ($urandom_range(1, 2)) @(negedge clk);
            reset = 1'b0;
        end else begin
            idle($urandom_range(1, 20));
        end
    endtask

    // Directed scenarios followed by the randomized phase.
    initial begin
        logic [31:0] rd;
        bit acked;
        int ackCount;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        idle(4 * DIV);
`ifdef SVSG_LZ_BLANK_EN
        checkDigit(3, 8'h00, "rst_d3");
        checkDigit(2, 8'h00, "rst_d2");
        checkDigit(1, 8'h00, "rst_d1");
`else
        checkDigit(3, 8'hFC, "rst_d3");
        checkDigit(2, 8'hFC, "rst_d2");
        checkDigit(1, 8'hFC, "rst_d1");
`endif
        checkDigit(0, 8'hFC, "rst_d0");

        wbWrite(BASE, 32'd1234, "wr1234_ack");
        wbRead(BASE + 32'd4, 32'h3, "ctrl_busy");
        idle(20);
        checkDigit(3, 8'h60, "v1234_d3");
        checkDigit(2, 8'hDA, "v1234_d2");
        checkDigit(1, 8'hF2, "v1234_d1");
        checkDigit(0, 8'h66, "v1234_d0");
        wbRead(BASE, 32'h4D2, "rd_1234");

        wbWrite(BASE, 32'd12000, "wr12000_ack");
        idle(20);
        wbRead(BASE + 32'd4, 32'h5, "ctrl_ovf");
        wbRead(BASE, 32'd9999, "rd_clamp");
        for (int i = 0; i < 4; i++) checkDigit(i, 8'hF6, "clamp_digit");

        wbWrite(BASE, 32'd5678, "wr5678_ack");
        idle(1);
        wbWrite(BASE, 32'd42, "wr42_ack");
        idle(20);
`ifdef SVSG_LZ_BLANK_EN
        checkDigit(3, 8'h00, "v42_d3");
        checkDigit(2, 8'h00, "v42_d2");
`else
        checkDigit(3, 8'hFC, "v42_d3");
        checkDigit(2, 8'hFC, "v42_d2");
`endif
        checkDigit(1, 8'h66, "v42_d1");
        checkDigit(0, 8'hDA, "v42_d0");

        wbWrite(BASE + 32'd4, 32'hFFFF_FFFE, "ctrl_off_ack");
        @(posedge clk);
        #2;
        checkOutput("off_dig_en", 32'(digEn), 32'd0);
        checkOutput("off_svsg", 32'(svsg), 32'd0);
        idle(2 * DIV);
        wbWrite(BASE + 32'd4, 32'd1, "ctrl_on_ack");
        checkDigit(0, 8'hDA, "resume_d0");

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'd8;
        ackCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (ack) ackCount++;
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        checkOutput("bad_adr_acks", 32'(ackCount), 32'd0);

        wbWrite(BASE, 32'd777, "wr777_ack");
        idle(4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wbRead(BASE + 32'd4, 32'h1, "ctrl_after_rst");
        wbRead(BASE, 32'h0, "value_after_rst");
        idle(20);
        checkDigit(0, 8'hFC, "rst_conv_d0");

        for (int i = 0; i < 300; i++) applyStimulus();
        wbAccess(BASE + 32'd4, 1'b1, 32'd1, rd, acked);
        idle(4 * DIV + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
